code_burst_gen: RTL and testbench

- Stimulus-side companion to the team's Mealy code-word detector.
- Each accepted command produces a burst of `cmd_len` consecutive CODE nibbles, followed by `cmd_gap` FILL nibbles.
- Output is a 4-bit valid/ready stream that drives the detector's nibble input.
- Publishes the number of detector hits the burst must produce (len-1), so a scoreboard can check the detector.

---
 rtl/code_gen_pkg.sv | 15 +
 rtl/code_burst_gen_down_counter.sv | 28 ++
 rtl/code_burst_gen.sv | 140 ++++++++++++++
 tb/tb_code_burst_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/code_gen_pkg.sv
// Shared types and defaults for the code-word burst generator.
package code_gen_pkg;

    // Generator FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Default nibble values: the detector's code word and the idle filler
    localparam logic [3:0] CODE_DEFAULT = 4'b1101;
    localparam logic [3:0] FILL_DEFAULT = 4'b0000;

endpackage

// File: rtl/code_burst_gen_down_counter.sv
// Loadable down counter with an "equals one" flag; stops at zero.
module down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             is_one
);

    logic [CNT_W-1:0] count;

    // Load has priority over decrement; decrement saturates at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign is_one = (count == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/code_burst_gen.sv
// Emits bursts of CODE nibbles followed by FILL nibbles on a valid/ready
// stream, one burst per accepted command, and publishes the hit count the
// downstream code-word detector should report for that burst.
module code_burst_gen
    import code_gen_pkg::*;
#(
    parameter logic [3:0] CODE  = CODE_DEFAULT,
    parameter logic [3:0] FILL  = FILL_DEFAULT,
    parameter int         CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [CNT_W-1:0] cmd_gap,
    output logic [3:0]       nib_out,
    output logic             nib_valid,
    input  logic             nib_ready,
    output logic             busy,
    output logic             burst_done,
    output logic [CNT_W-1:0] exp_hits
);

    // A CODE-coloured gap would be indistinguishable from the burst itself
    generate
        if (CODE == FILL) begin : g_bad_params
            $error("code_burst_gen: CODE and FILL must differ");
        end
    endgenerate

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] gap_q;
    logic             accept;
    logic             xfer;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic             cnt_is_one;
    logic             done_nxt;

    assign accept    = cmd_valid && cmd_ready;
    assign xfer      = nib_valid && nib_ready;

    // Moore outputs: depend on state only, never on nib_ready
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign nib_valid = (state != IDLE);
    assign nib_out   = (state == BURST) ? CODE : FILL;

    // One counter serves both phases: loaded with len, then reloaded with gap
    down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .is_one   (cnt_is_one)
    );

    // Next-state, counter control and completion detection
    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = cmd_len;
        cnt_en       = 1'b0;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_len != '0) begin
                        state_nxt    = BURST;
                        cnt_load     = 1'b1;
                        cnt_load_val = cmd_len;
                    end else if (cmd_gap != '0) begin
                        state_nxt    = GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = cmd_gap;
                    end else begin
                        // Empty command completes without leaving IDLE
                        done_nxt = 1'b1;
                    end
                end
            end
            BURST: begin
                if (xfer) begin
                    if (cnt_is_one && (gap_q != '0)) begin
                        state_nxt    = GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = gap_q;
                    end else begin
                        cnt_en = 1'b1;
                        if (cnt_is_one) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (xfer) begin
                    cnt_en = 1'b1;
                    if (cnt_is_one) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, completion pulse and published hit count
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            burst_done <= 1'b0;
            exp_hits   <= '0;
        end else begin
            state      <= state_nxt;
            burst_done <= done_nxt;
            if (accept) begin
                exp_hits <= (cmd_len >= 2) ? (cmd_len - ONE) : '0;
            end
        end
    end

    // Gap length is captured at accept so later cmd_* changes are ignored
    always_ff @(posedge clk) begin
        if (accept) begin
            gap_q <= cmd_gap;
        end
    end

endmodule

// File: tb/tb_code_burst_gen.sv
// Directed bench for code_burst_gen: expected nibbles are queued at command
// accept and popped on every stream transfer; a simple detector model counts
// adjacent CODE pairs to cross-check the published hit count.
module tb_code_burst_gen;
    import code_gen_pkg::*;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_len;
    logic [CNT_W-1:0] cmd_gap;
    logic [3:0]       nib_out;
    logic             nib_valid;
    logic             nib_ready;
    logic             busy;
    logic             burst_done;
    logic [CNT_W-1:0] exp_hits;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] sb[$];

    code_burst_gen #(
        .CODE  (CODE_DEFAULT),
        .FILL  (FILL_DEFAULT),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_gap    (cmd_gap),
        .nib_out    (nib_out),
        .nib_valid  (nib_valid),
        .nib_ready  (nib_ready),
        .busy       (busy),
        .burst_done (burst_done),
        .exp_hits   (exp_hits)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Issue one command in the current (IDLE) cycle and follow it to completion.
    // mode 0: nib_ready always high; mode 1: nib_ready pattern 1,0,0 repeating.
    task automatic run_cmd(input int len, input int gap, input int mode);
        int         exp_h;
        int         total;
        int         cyc;
        int         hits_seen;
        bit         prev_code;
        bit         prev_stall;
        bit         done_seen;
        logic [3:0] prev_out;
        logic [3:0] want;
        exp_h      = (len >= 2) ? len - 1 : 0;
        total      = len + gap;
        cyc        = 0;
        hits_seen  = 0;
        prev_code  = 1'b0;
        prev_stall = 1'b0;
        done_seen  = 1'b0;
        prev_out   = FILL_DEFAULT;

        chk("pre_cmd_ready", {31'd0, cmd_ready}, 1);
        chk("pre_idle_valid", {31'd0, nib_valid}, 0);

        for (int i = 0; i < len; i++) sb.push_back(CODE_DEFAULT);
        for (int i = 0; i < gap; i++) sb.push_back(FILL_DEFAULT);

        cmd_valid = 1'b1;
        cmd_len   = CNT_W'(len);
        cmd_gap   = CNT_W'(gap);
        nib_ready = (mode == 0);
        tick();
        // Scramble command inputs: the running command must ignore them
        cmd_valid = 1'b0;
        cmd_len   = CNT_W'($urandom);
        cmd_gap   = CNT_W'($urandom);

        chk("exp_hits", {24'd0, exp_hits}, exp_h);
        if (total == 0) begin
            chk("empty_done", {31'd0, burst_done}, 1);
            chk("empty_ready", {31'd0, cmd_ready}, 1);
            chk("empty_valid", {31'd0, nib_valid}, 0);
            return;
        end
        chk("done_pulse_width", {31'd0, burst_done}, 0);
        chk("first_valid", {31'd0, nib_valid}, 1);
        chk("busy", {31'd0, busy}, 1);

        while (!done_seen && cyc < 4 * total + 10) begin
            nib_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            chk("cmd_ready_busy", {31'd0, cmd_ready}, 0);
            if (prev_stall) begin
                chk("stall_valid", {31'd0, nib_valid}, 1);
                chk("stall_hold", {28'd0, nib_out}, {28'd0, prev_out});
            end
            if (nib_valid && nib_ready) begin
                chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 1);
                if (sb.size() != 0) begin
                    want = sb.pop_front();
                    chk("nib_out", {28'd0, nib_out}, {28'd0, want});
                end
                if (nib_out == CODE_DEFAULT) begin
                    if (prev_code) hits_seen++;
                    prev_code = 1'b1;
                end else begin
                    prev_code = 1'b0;
                end
            end
            prev_stall = nib_valid && !nib_ready;
            prev_out   = nib_out;
            tick();
            cyc++;
            if (burst_done) done_seen = 1'b1;
        end

        chk("done_seen", {31'd0, done_seen}, 1);
        chk("sb_drained", sb.size(), 0);
        chk("detector_hits", hits_seen, exp_h);
        chk("exp_hits_hold", {24'd0, exp_hits}, exp_h);
        if (mode == 0) chk("contig_cycles", cyc, total);
        chk("idle_valid_after", {31'd0, nib_valid}, 0);
        chk("idle_out_after", {28'd0, nib_out}, {28'd0, FILL_DEFAULT});
        chk("busy_after", {31'd0, busy}, 0);
        sb.delete();
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_gap   = '0;
        nib_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_valid", {31'd0, nib_valid}, 0);
        chk("rst_out", {28'd0, nib_out}, {28'd0, FILL_DEFAULT});
        chk("rst_ready", {31'd0, cmd_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, burst_done}, 0);
        chk("rst_hits", {24'd0, exp_hits}, 0);
        tick();

        run_cmd(3, 2, 0);
        run_cmd(1, 0, 0);
        run_cmd(4, 1, 1);
        // Empty command, then a new command accepted in the burst_done cycle
        run_cmd(0, 0, 0);
        run_cmd(2, 1, 0);
        // Back-to-back gap==0 commands: one idle cycle separates them
        run_cmd(2, 0, 0);
        run_cmd(3, 0, 0);
        tick();

        // Reset after 2 of 5 CODE transfers
        cmd_valid = 1'b1;
        cmd_len   = 8'd5;
        cmd_gap   = 8'd1;
        nib_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("mid_hits", {24'd0, exp_hits}, 4);
        chk("mid_out1", {28'd0, nib_out}, {28'd0, CODE_DEFAULT});
        tick();
        chk("mid_out2", {28'd0, nib_out}, {28'd0, CODE_DEFAULT});
        tick();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        nib_ready = 1'b0;
        chk("mrst_valid", {31'd0, nib_valid}, 0);
        chk("mrst_ready", {31'd0, cmd_ready}, 1);
        chk("mrst_hits", {24'd0, exp_hits}, 0);
        chk("mrst_done", {31'd0, burst_done}, 0);
        tick();
        chk("mrst_no_done", {31'd0, burst_done}, 0);
        chk("mrst_idle", {31'd0, nib_valid}, 0);
        run_cmd(2, 1, 0);

        // Full-range length
        run_cmd(255, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
